// File: rtl/bridge_uart_tx.sv
// Serialises {mode, addr, data} packets from the bus bridge onto a UART TX line,
// MSB byte first, with a one-deep holding register for back-to-back packets.
module bridge_uart_tx #(
   parameter  int ADDR_WIDTH   = 16,
   parameter  int DATA_WIDTH   = 8,
   parameter  int CLKS_PER_BIT = 434,
   localparam int PKT_WIDTH    = 1 + ADDR_WIDTH + DATA_WIDTH,
   localparam int NUM_BYTES    = (PKT_WIDTH + 7) / 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [PKT_WIDTH-1:0] packet_in,
   input  logic                 valid_in,
   output logic                 tx,
   output logic                 busy,
   output logic                 ready,
   output logic                 done,
   output logic                 overflow
);

   localparam int FRAME_W = NUM_BYTES * 8;
   localparam int BAUD_W  = $clog2(CLKS_PER_BIT);
   localparam int BYTE_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam logic [BAUD_W-1:0] BAUD_MAX  = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t               r_state;
   state_t               w_next;
   logic [BAUD_W-1:0]    r_baud;
   logic [2:0]           r_bit;
   logic [BYTE_W-1:0]    r_byte;
   logic [FRAME_W-1:0]   r_shift;
   logic [PKT_WIDTH-1:0] r_hold;
   logic                 r_hold_full;
   logic                 r_tx;
   logic                 r_done;
   logic                 r_ovf;

   logic       w_baud_end;
   logic       w_last_byte;
   logic       w_stop_end;
   logic       w_frame_end;
   logic       w_drain;
   logic       w_load_direct;
   logic       w_hold_load;
   logic       w_drop;
   logic [7:0] w_cur_byte;
   logic       w_line;

   assign w_baud_end  = (r_baud == BAUD_MAX);
   assign w_last_byte = (r_byte == BYTE_LAST);
   assign w_stop_end  = (r_state == STOP) && w_baud_end;
   assign w_frame_end = w_stop_end && w_last_byte;
   assign w_drain     = w_frame_end && r_hold_full;

   // A strobe landing on the final stop expiry with nothing held goes straight
   // to the shift register so it is neither lost nor delayed by an idle cycle.
   assign w_load_direct = valid_in && ((r_state == IDLE) || (w_frame_end && !r_hold_full));
   assign w_hold_load   = valid_in && (r_state != IDLE) && !w_load_direct
                          && (!r_hold_full || w_drain);
   assign w_drop        = valid_in && (r_state != IDLE) && r_hold_full && !w_drain;

   assign w_cur_byte = 8'(r_shift >> (8 * (NUM_BYTES - 1 - int'(r_byte))));

   always_comb begin
      w_next = r_state;
      w_line = 1'b1;
      case (r_state)
         IDLE: begin
            if (valid_in) w_next = START;
         end
         START: begin
            w_line = 1'b0;
            if (w_baud_end) w_next = DATA;
         end
         DATA: begin
            w_line = w_cur_byte[r_bit];
            if (w_baud_end && (r_bit == 3'd7)) w_next = STOP;
         end
         STOP: begin
            if (w_baud_end) begin
               if (!w_last_byte || r_hold_full || valid_in) w_next = START;
               else                                         w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_baud      <= '0;
         r_bit       <= '0;
         r_byte      <= '0;
         r_hold_full <= 1'b0;
         r_tx        <= 1'b1;
         r_done      <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         r_state <= w_next;
         r_tx    <= w_line;
         r_done  <= w_frame_end;

         if ((r_state == IDLE) || w_baud_end) r_baud <= '0;
         else                                 r_baud <= r_baud + 1'b1;

         if ((r_state == DATA) && w_baud_end) r_bit <= r_bit + 3'd1;

         if (w_stop_end) begin
            if (w_last_byte) r_byte <= '0;
            else             r_byte <= r_byte + 1'b1;
         end

         if (w_hold_load)  r_hold_full <= 1'b1;
         else if (w_drain) r_hold_full <= 1'b0;

         if (w_drop) r_ovf <= 1'b1;
      end
   end

   // Packet storage carries no reset; its validity is tracked by the control state.
   always_ff @(posedge clk) begin
      if (w_load_direct)  r_shift <= FRAME_W'(packet_in);
      else if (w_drain)   r_shift <= FRAME_W'(r_hold);
      if (w_hold_load)    r_hold  <= packet_in;
   end

   assign tx       = r_tx;
   assign busy     = (r_state != IDLE);
   assign ready    = !r_hold_full;
   assign done     = r_done;
   assign overflow = r_ovf;

endmodule
